// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch + IF/ID pipeline register for the RV64 core.
// One outstanding request on the valid/ready imem port; the returned word is
// captured into IF/ID (or parked in a hold buffer while decode is stalled).
// Branch redirects flush the stage and may need to drain one stale response.
//
// Ports
//   clk, rst_n          : rising-edge clock, async active-low reset
//   imem_req_valid/ready: request handshake, imem_addr = current pc
//   imem_rsp_valid/data : response word (at most one per accepted request)
//   stall               : decode cannot accept; IF/ID holds
//   redirect_valid/pc   : taken branch/jump target (bits [1:0] forced to 0)
//   id_valid/pc/instruction/opcode : IF/ID register outputs
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_instruction,
  output logic [6:0]  id_opcode
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } hold_t;

  state_t      state, state_nxt;
  logic [63:0] pc;
  hold_t       hold;

  logic        hs;
  logic        ld_rsp, st_hold, ld_hold;
  logic [63:0] tgt;

  assign hs  = (state == S_REQ) && imem_req_ready;
  // Masking rather than slicing keeps every redirect_pc bit in use.
  assign tgt = redirect_pc & ~64'h3;

  // Datapath strobes; a redirect overrides all of them.
  assign ld_rsp  = !redirect_valid && (state == S_WAIT) && imem_rsp_valid && !stall;
  assign st_hold = !redirect_valid && (state == S_WAIT) && imem_rsp_valid &&  stall;
  assign ld_hold = !redirect_valid && (state == S_HOLD) && !stall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_REQ;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      // Drain only when a response is still owed for an accepted request.
      unique case (state)
        S_REQ:   state_nxt = hs             ? S_DRAIN : S_REQ;
        S_WAIT:  state_nxt = imem_rsp_valid ? S_REQ   : S_DRAIN;
        S_DRAIN: state_nxt = imem_rsp_valid ? S_REQ   : S_DRAIN;
        default: state_nxt = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ:   if (hs) state_nxt = S_WAIT;
        S_WAIT:  if (imem_rsp_valid) state_nxt = stall ? S_HOLD : S_REQ;
        S_HOLD:  if (!stall) state_nxt = S_REQ;
        S_DRAIN: if (imem_rsp_valid) state_nxt = S_REQ;
        default: state_nxt = S_REQ;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    imem_req_valid = (state == S_REQ);
    imem_addr      = pc;
  end

  // PC, hold buffer, IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      hold           <= '0;
      id_valid       <= 1'b0;
      id_pc          <= 64'h0;
      id_instruction <= NOP;
      id_opcode      <= NOP[6:0];
    end else if (redirect_valid) begin
      pc             <= tgt;
      hold           <= '0;
      id_valid       <= 1'b0;
      id_instruction <= NOP;
      id_opcode      <= NOP[6:0];
    end else begin
      if (ld_rsp || ld_hold) pc <= pc + 64'd4;
      if (st_hold) hold <= '{pc: pc, instr: imem_rsp_data};
      if (ld_rsp) begin
        id_valid       <= 1'b1;
        id_pc          <= pc;
        id_instruction <= imem_rsp_data;
        id_opcode      <= imem_rsp_data[6:0];
      end else if (ld_hold) begin
        id_valid       <= 1'b1;
        id_pc          <= hold.pc;
        id_instruction <= hold.instr;
        id_opcode      <= hold.instr[6:0];
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  logic        req_valid,  req_valid2;
  logic [63:0] addr,       addr2;
  logic        id_valid,   id_valid2;
  logic [63:0] id_pc,      id_pc2;
  logic [31:0] id_instr,   id_instr2;
  logic [6:0]  id_opc,     id_opc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(64'h1000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready), .imem_addr(addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_instruction(id_instr), .id_opcode(id_opc)
  );

  fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid2), .imem_req_ready(imem_req_ready), .imem_addr(addr2),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid2), .id_pc(id_pc2), .id_instruction(id_instr2), .id_opcode(id_opc2)
  );

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic idle_inputs();
    imem_rsp_valid = 0; imem_rsp_data = 32'h0; stall = 0;
    redirect_valid = 0; redirect_pc = 64'h0; imem_req_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 0;
    #3;
    chk("rst_req_valid", req_valid, 1);
    chk("rst_addr", addr, 64'h1000);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_instr", id_instr, 32'h13);
    chk("rst_id_opc", id_opc, 7'h13);
    tick();
    rst_n = 1;
  endtask

  // Fetch 0x1000 with a 1-cycle memory; handshake on the first edge after reset.
  task automatic test_fetch();
    tick();                                  // handshake for 0x1000
    chk("f_req_valid_wait", req_valid, 0);
    chk("f_addr_wait", addr, 64'h1000);
    imem_rsp_valid = 1; imem_rsp_data = 32'h0050_0093;
    tick();                                  // response captured
    imem_rsp_valid = 0;
    chk("f_id_valid", id_valid, 1);
    chk("f_id_pc", id_pc, 64'h1000);
    chk("f_id_instr", id_instr, 32'h0050_0093);
    chk("f_id_opc", id_opc, 7'h13);
    chk("f_addr_next", addr, 64'h1004);
    chk("f_req_valid_next", req_valid, 1);
  endtask

  task automatic test_stall();
    tick();                                  // handshake for 0x1004
    imem_rsp_valid = 1; imem_rsp_data = 32'h0000_006F; stall = 1;
    tick();                                  // response parked in hold buffer
    imem_rsp_valid = 0;
    chk("s_id_pc_held", id_pc, 64'h1000);
    chk("s_id_instr_held", id_instr, 32'h0050_0093);
    chk("s_req_valid_hold", req_valid, 0);
    tick();
    chk("s_id_instr_held2", id_instr, 32'h0050_0093);
    chk("s_addr_hold", addr, 64'h1004);
    stall = 0;
    tick();                                  // release
    chk("s_id_pc_rel", id_pc, 64'h1004);
    chk("s_id_instr_rel", id_instr, 32'h0000_006F);
    chk("s_id_opc_rel", id_opc, 7'h6F);
    chk("s_id_valid_rel", id_valid, 1);
    chk("s_addr_rel", addr, 64'h1008);
    chk("s_req_valid_rel", req_valid, 1);
  endtask

  task automatic test_redirect_wait();
    tick();                                  // handshake for 0x1008
    redirect_valid = 1; redirect_pc = 64'h2003;
    tick();                                  // redirect with request outstanding
    redirect_valid = 0;
    chk("rw_id_valid", id_valid, 0);
    chk("rw_id_instr", id_instr, 32'h13);
    chk("rw_req_valid_drain", req_valid, 0);
    imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();                                  // stale response dropped
    imem_rsp_valid = 0;
    chk("rw_id_valid_drop", id_valid, 0);
    chk("rw_id_instr_drop", id_instr, 32'h13);
    chk("rw_req_valid", req_valid, 1);
    chk("rw_addr", addr, 64'h2000);
    tick();                                  // handshake for 0x2000
    imem_rsp_valid = 1; imem_rsp_data = 32'h1234_50B7;
    tick();
    imem_rsp_valid = 0;
    chk("rw_id_valid_new", id_valid, 1);
    chk("rw_id_pc_new", id_pc, 64'h2000);
    chk("rw_id_instr_new", id_instr, 32'h1234_50B7);
    chk("rw_id_opc_new", id_opc, 7'h37);
    chk("rw_addr_new", addr, 64'h2004);
  endtask

  task automatic test_redirect_stall_rsp();
    tick();                                  // handshake for 0x2004
    imem_rsp_valid = 1; imem_rsp_data = 32'hCAFE_F00D;
    stall = 1; redirect_valid = 1; redirect_pc = 64'h3000;
    tick();
    idle_inputs();
    chk("rs_id_valid", id_valid, 0);
    chk("rs_id_instr", id_instr, 32'h13);
    chk("rs_id_opc", id_opc, 7'h13);
    chk("rs_req_valid", req_valid, 1);
    chk("rs_addr", addr, 64'h3000);
  endtask

  // No handshake: request stays up; a redirect then moves the address directly.
  task automatic test_no_handshake();
    imem_req_ready = 0;
    tick();
    chk("nh_req_valid", req_valid, 1);
    chk("nh_addr", addr, 64'h3000);
    redirect_valid = 1; redirect_pc = 64'h4006;
    tick();
    redirect_valid = 0;
    chk("nh_req_valid_rd", req_valid, 1);
    chk("nh_addr_rd", addr, 64'h4004);
    imem_req_ready = 1;
    tick();                                  // handshake for 0x4004
    chk("nh_req_valid_acc", req_valid, 0);
  endtask

  task automatic test_wrap();
    do_reset();
    chk("w_addr_reset", addr2, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0013;
    tick();
    imem_rsp_valid = 0;
    chk("w_id_pc", id_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("w_addr_wrap", addr2, 64'h0);
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    tick();
    imem_rsp_valid = 1; imem_rsp_data = 32'h0050_0093;
    tick();                                  // 0x1000 in IF/ID
    imem_rsp_valid = 0;
    tick();                                  // handshake for 0x1004
    imem_rsp_valid = 1; imem_rsp_data = 32'h0000_006F; stall = 1;
    tick();                                  // in S_HOLD
    imem_rsp_valid = 0;
    chk("rh_id_valid_pre", id_valid, 1);
    chk("rh_req_valid_pre", req_valid, 0);
    #2 rst_n = 0;                            // asynchronous, mid-cycle
    #1;
    chk("rh_id_valid", id_valid, 0);
    chk("rh_id_instr", id_instr, 32'h13);
    chk("rh_id_pc", id_pc, 0);
    chk("rh_addr", addr, 64'h1000);
    chk("rh_req_valid", req_valid, 1);
    stall = 0;
    tick();
    rst_n = 1;
    tick();                                  // stale hold contents must not appear
    chk("rh_id_valid_after", id_valid, 0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_stall_rsp();
    test_no_handshake();
    test_wrap();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
